// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared state/response encodings and limits for the Wishbone
// classic memory device model.
package wishbone_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} dev_state_t;
   typedef enum logic [1:0] {RESP_ACK, RESP_ERR, RESP_RTY} wb_resp_t;
   localparam int MAX_WAIT_CYCLES = 15;
endpackage

// File: rtl/wishbone_classic_mem_dev_storage.sv
// wb_mem_dev_storage: byte-enabled single-port synchronous RAM with a registered
// read port; contents are never reset.
module wb_mem_dev_storage #(
   parameter int DEPTH      = 256,
   parameter int DATA_WIDTH = 32,
   parameter int AW         = 8
) (
   input  logic                      clk_i,
   input  logic                      we_i,
   input  logic [AW-1:0]             adr_i,
   input  logic [DATA_WIDTH-1:0]     dat_i,
   input  logic [DATA_WIDTH/8-1:0]   sel_i,
   output logic [DATA_WIDTH-1:0]     dat_o
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_q;

   always_ff @(posedge clk_i) begin
      for (int k = 0; k < DATA_WIDTH / 8; k++)
         if (we_i && sel_i[k]) mem[adr_i][8*k +: 8] <= dat_i[8*k +: 8];
      rd_q <= mem[adr_i];
   end

   assign dat_o = rd_q;
endmodule

// File: rtl/wishbone_classic_mem_dev.sv
// wishbone_classic_mem_dev: Wishbone classic device with wait states, error and retry
// responses over a byte-enabled memory; define WB_MEM_DEV_FORMAL_EN for embedded properties.
module wishbone_classic_mem_dev
   import wishbone_pkg::*;
#(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int DEPTH       = 256,
   parameter int WAIT_CYCLES = 0,
   parameter int RTY_PERIOD  = 0
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    rty_o
);
   localparam int SW = DATA_WIDTH / 8;
   localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(MAX_WAIT_CYCLES + 1);
   localparam int RW = RTY_PERIOD > 1 ? $clog2(RTY_PERIOD) : 1;

   dev_state_t            state_q, state_d;
   wb_resp_t              resp_q, resp_d, resp_now;
   logic [CW-1:0]         wcnt_q, wcnt_d;
   logic [RW-1:0]         rcnt_q, rcnt_d;
   logic                  we_q, we_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic [SW-1:0]         sel_q, sel_d;
   logic                  ack_q, ack_d, err_q, err_d, rty_q, rty_d;
   logic                  req, in_range, rty_due, term, mem_we;
   logic [ADDR_WIDTH-1:0] mem_adr;
   logic [DATA_WIDTH-1:0] rd_data;

   assign req      = cyc_i && stb_i;
   assign in_range = int'(adr_i) < DEPTH;
   assign rty_due  = RTY_PERIOD != 0 && rcnt_q == RW'(RTY_PERIOD - 1);
   assign resp_now = !in_range ? RESP_ERR : rty_due ? RESP_RTY : RESP_ACK;

   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      rcnt_d  = rcnt_q;
      we_d    = we_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      sel_d   = sel_q;
      resp_d  = resp_q;
      term    = 1'b0;
      if (state_q == IDLE) begin
         if (req) begin
            we_d   = we_i;
            adr_d  = adr_i;
            dat_d  = dat_i;
            sel_d  = sel_i;
            resp_d = resp_now;
            if (in_range && RTY_PERIOD != 0) rcnt_d = rty_due ? '0 : rcnt_q + 1'b1;
            if (WAIT_CYCLES == 0) begin
               state_d = RESP;
               term    = 1'b1;
            end else begin
               state_d = WAIT;
               wcnt_d  = CW'(WAIT_CYCLES);
            end
         end
      end else if (state_q == WAIT) begin
         wcnt_d = wcnt_q - 1'b1;
         if (!req) state_d = IDLE;
         else if (wcnt_q == CW'(1)) begin
            state_d = RESP;
            term    = 1'b1;
         end
      end else begin
         state_d = IDLE;
      end
      ack_d = term && resp_d == RESP_ACK;
      err_d = term && resp_d == RESP_ERR;
      rty_d = term && resp_d == RESP_RTY;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         resp_q  <= RESP_ACK;
         wcnt_q  <= '0;
         rcnt_q  <= '0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         rty_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         resp_q  <= resp_d;
         wcnt_q  <= wcnt_d;
         rcnt_q  <= rcnt_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rty_q   <= rty_d;
      end
   end

   // In IDLE the live address feeds the RAM so a zero-wait read lands in RESP.
   assign mem_adr = state_q == IDLE ? adr_i : adr_q;
   assign mem_we  = ack_q && we_q && req;

   wb_mem_dev_storage #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .AW(MW)) u_storage (
      .clk_i (clk_i),
      .we_i  (mem_we),
      .adr_i (mem_adr[MW-1:0]),
      .dat_i (dat_q),
      .sel_i (sel_q),
      .dat_o (rd_data)
   );

   assign dat_o = ack_q ? rd_data : '0;
   assign ack_o = ack_q;
   assign err_o = err_q;
   assign rty_o = rty_q;

`ifdef WB_MEM_DEV_FORMAL_EN
   default clocking fcb @(posedge clk_i); endclocking
   default disable iff (rst_i);
   logic [2:0] f_term;
   assign f_term = {ack_o, err_o, rty_o};
   asm_stb_cyc: assume property (stb_i |-> cyc_i);
   asm_stable:  assume property (state_q != IDLE && req |-> $stable({we_i, adr_i, dat_i, sel_i}));
   ast_onehot:  assert property ($onehot0(f_term));
   ast_req:     assert property (|f_term |-> $past(req));
   ast_pulse:   assert property (|f_term |=> !(|f_term));
   cov_ack:     cover property (ack_o);
   cov_err:     cover property (err_o);
   cov_rty:     cover property (rty_o);
`endif
endmodule

// File: tb/tb_wishbone_classic_mem_dev.sv
// tb_wishbone_classic_mem_dev: directed checks of three device configurations
// (zero-wait 9-bit address, 3 waits with retry every 3rd, 4 waits).
module tb_wishbone_classic_mem_dev;
   localparam logic [2:0] ACK = 3'b100, ERR = 3'b010, RTY = 3'b001, NONE = 3'b000;

   logic clk = 1'b0, rst = 1'b1, stb = 1'b0, we = 1'b0;
   logic [2:0] cyc = '0;
   logic [8:0] adr = '0;
   logic [31:0] dat = '0;
   logic [3:0] sel = '0;
   logic [2:0][2:0] trm;
   logic [2:0][31:0] dq;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   wishbone_classic_mem_dev #(.ADDR_WIDTH(9), .DEPTH(256)) d0 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[0]), .stb_i(stb), .we_i(we), .adr_i(adr),
      .dat_i(dat), .sel_i(sel), .dat_o(dq[0]), .ack_o(trm[0][2]), .err_o(trm[0][1]), .rty_o(trm[0][0]));
   wishbone_classic_mem_dev #(.WAIT_CYCLES(3), .RTY_PERIOD(3)) d3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[1]), .stb_i(stb), .we_i(we), .adr_i(adr[7:0]),
      .dat_i(dat), .sel_i(sel), .dat_o(dq[1]), .ack_o(trm[1][2]), .err_o(trm[1][1]), .rty_o(trm[1][0]));
   wishbone_classic_mem_dev #(.WAIT_CYCLES(4)) d4 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc[2]), .stb_i(stb), .we_i(we), .adr_i(adr[7:0]),
      .dat_i(dat), .sel_i(sel), .dat_o(dq[2]), .ack_o(trm[2][2]), .err_o(trm[2][1]), .rty_o(trm[2][0]));

   // One classic transfer on device d; lat = -1 when no termination arrives in time.
   task automatic xfer(input int d, input logic w, input logic [8:0] a, input logic [31:0] wd,
                       input logic [3:0] s, output logic [2:0] t, output logic [31:0] rd,
                       output int lat, output logic pre, output logic [2:0] aft);
      we = w; adr = a; dat = wd; sel = s; stb = 1'b1; cyc[d] = 1'b1;
      t = NONE; rd = '0; lat = -1; pre = 1'b0; aft = NONE;
      for (int i = 1; i <= 40 && lat < 0; i++) begin
         @(posedge clk); #1;
         if (trm[d] != NONE) begin
            t = trm[d]; rd = dq[d]; lat = i;
         end else pre = pre | (|dq[d]);
      end
      if (lat > 0) begin
         @(posedge clk); #1;
         aft = trm[d];
      end
      stb = 1'b0; cyc[d] = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({trm[i], dq[i]} !== 35'b0) begin
            failures++;
            $display("FAIL reset_outputs dut=%0d term=%b dat=%h expected 000/0", i, trm[i], dq[i]);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      xfer(0, 1'b1, 9'h010, 32'hDEADBEEF, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || lat !== 1) begin
         failures++; $display("FAIL wr_ack term=%b lat=%0d expected %b lat=1", t, lat, ACK);
      end
      checks++;
      if (aft !== NONE) begin
         failures++; $display("FAIL wr_one_cycle term_after=%b expected %b", aft, NONE);
      end
      xfer(0, 1'b0, 9'h010, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || lat !== 1) begin
         failures++; $display("FAIL rd_ack term=%b lat=%0d expected %b lat=1", t, lat, ACK);
      end
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         failures++; $display("FAIL rd_data got=%h expected deadbeef", rd);
      end
   endtask

   task automatic test_byte_lanes();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      xfer(0, 1'b1, 9'h010, 32'h11223344, 4'h5, t, rd, lat, pre, aft);
      xfer(0, 1'b0, 9'h010, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (rd !== 32'hDE22BE44) begin
         failures++; $display("FAIL byte_lanes got=%h expected de22be44", rd);
      end
      xfer(0, 1'b1, 9'h010, 32'hFFFFFFFF, 4'h0, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK) begin
         failures++; $display("FAIL sel0_ack term=%b expected %b", t, ACK);
      end
      xfer(0, 1'b0, 9'h010, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (rd !== 32'hDE22BE44) begin
         failures++; $display("FAIL sel0_nochange got=%h expected de22be44", rd);
      end
   endtask

   task automatic test_out_of_range();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      xfer(0, 1'b1, 9'h000, 32'h0BADF00D, 4'hF, t, rd, lat, pre, aft);
      xfer(0, 1'b1, 9'h100, 32'hCAFEF00D, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ERR || lat !== 1 || aft !== NONE) begin
         failures++; $display("FAIL oor_wr_err term=%b lat=%0d after=%b expected %b lat=1 after=000", t, lat, aft, ERR);
      end
      xfer(0, 1'b0, 9'h1FF, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ERR || rd !== 32'h0) begin
         failures++; $display("FAIL oor_rd_err term=%b dat=%h expected %b dat=0", t, rd, ERR);
      end
      xfer(0, 1'b0, 9'h000, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || rd !== 32'h0BADF00D) begin
         failures++; $display("FAIL oor_mem_unchanged term=%b dat=%h expected %b dat=0badf00d", t, rd, ACK);
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      logic [3:0] pat;
      we = 1'b1; adr = 9'h030; dat = 32'h00000055; sel = 4'hF; stb = 1'b1; cyc[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         pat[3-i] = trm[0][2];
      end
      stb = 1'b0; cyc[0] = 1'b0;
      checks++;
      if (pat !== 4'b1010) begin
         failures++; $display("FAIL held_req_period ack_pattern=%b expected 1010", pat);
      end
      xfer(0, 1'b0, 9'h030, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (rd !== 32'h00000055) begin
         failures++; $display("FAIL b2b_data got=%h expected 00000055", rd);
      end
   endtask

   task automatic test_wait_states();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      xfer(1, 1'b1, 9'h005, 32'hA5A50001, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || lat !== 4) begin
         failures++; $display("FAIL wait_wr term=%b lat=%0d expected %b lat=4", t, lat, ACK);
      end
      xfer(1, 1'b0, 9'h005, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || lat !== 4 || aft !== NONE) begin
         failures++; $display("FAIL wait_rd term=%b lat=%0d after=%b expected %b lat=4 after=000", t, lat, aft, ACK);
      end
      checks++;
      if (pre !== 1'b0) begin
         failures++; $display("FAIL wait_dat_zero early_dat_nonzero=%b expected 0", pre);
      end
      checks++;
      if (rd !== 32'hA5A50001) begin
         failures++; $display("FAIL wait_rd_data got=%h expected a5a50001", rd);
      end
   endtask

   task automatic test_retry();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      logic [2:0] exp_t [4] = '{RTY, ACK, ACK, RTY};
      logic [31:0] exp_d [4] = '{32'h0, 32'hA5A50001, 32'hA5A50001, 32'h0};
      for (int i = 0; i < 4; i++) begin
         xfer(1, 1'b0, 9'h005, 32'h0, 4'hF, t, rd, lat, pre, aft);
         checks++;
         if (t !== exp_t[i] || rd !== exp_d[i] || lat !== 4) begin
            failures++;
            $display("FAIL retry_seq%0d term=%b dat=%h lat=%0d expected %b dat=%h lat=4", i, t, rd, lat, exp_t[i], exp_d[i]);
         end
      end
   endtask

   task automatic test_abort_reset();
      logic [2:0] t, aft; logic [31:0] rd; int lat; logic pre;
      logic seen, got;
      xfer(2, 1'b1, 9'h007, 32'h12345678, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || lat !== 5) begin
         failures++; $display("FAIL w4_wr term=%b lat=%0d expected %b lat=5", t, lat, ACK);
      end
      we = 1'b1; adr = 9'h007; dat = 32'hFFFFFFFF; sel = 4'hF; stb = 1'b1; cyc[2] = 1'b1;
      repeat (2) @(posedge clk);
      #1; stb = 1'b0; cyc[2] = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         seen = seen | (|trm[2]);
      end
      checks++;
      if (seen !== 1'b0) begin
         failures++; $display("FAIL abort_no_term seen=%b expected 0", seen);
      end
      xfer(2, 1'b0, 9'h007, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || rd !== 32'h12345678) begin
         failures++; $display("FAIL abort_no_write term=%b dat=%h expected %b dat=12345678", t, rd, ACK);
      end
      we = 1'b1; adr = 9'h007; dat = 32'h0BADBEEF; sel = 4'hF; stb = 1'b1; cyc[2] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         @(posedge clk); #1;
         got = trm[2][2];
      end
      checks++;
      if (got !== 1'b1) begin
         failures++; $display("FAIL rst_setup_ack got=%b expected 1", got);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({trm[2], dq[2]} !== 35'b0) begin
         failures++; $display("FAIL rst_immediate term=%b dat=%h expected 000/0", trm[2], dq[2]);
      end
      stb = 1'b0; cyc[2] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      xfer(2, 1'b0, 9'h007, 32'h0, 4'hF, t, rd, lat, pre, aft);
      checks++;
      if (t !== ACK || rd !== 32'h12345678) begin
         failures++; $display("FAIL rst_no_write term=%b dat=%h expected %b dat=12345678", t, rd, ACK);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_out_of_range();
      test_back_to_back();
      test_wait_states();
      test_retry();
      test_abort_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end
endmodule
